// File: rtl/panel_frame_sched.sv
// Frame-level scheduler for ledpanel: double-buffer handoff at frame boundaries,
// shadowed panel configuration, panel enable/reset sequencing and a frame watchdog.
module panel_frame_sched #(
  parameter int unsigned N_ROWS_MAX    = 64,
  parameter int unsigned N_COLS_MAX    = 256,
  parameter int unsigned BITDEPTH_MAX  = 8,
  parameter int unsigned LSB_BLANK_MAX = 200,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned FRAME_TIMEOUT = 2**24
) (
  input  logic        clk,
  input  logic        ctrl_rst,
  input  logic        run_en,
  input  logic [31:0] cfg_n_rows,
  input  logic [31:0] cfg_n_cols,
  input  logic [31:0] cfg_bitdepth,
  input  logic [31:0] cfg_lsb_blank,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        cfg_err,
  input  logic        wr_swap_req,
  output logic        wr_swap_ack,
  output logic        wr_buffer,
  input  logic        frame_done,
  output logic        disp_buffer,
  output logic        panel_en,
  output logic        panel_rst,
  output logic [31:0] panel_n_rows,
  output logic [31:0] panel_n_cols,
  output logic [31:0] panel_bitdepth,
  output logic [31:0] panel_lsb_blank,
  output logic        fault
);

  localparam int unsigned WD_W = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PRST, RUN} state_t;

  state_t state, state_nx;

  logic            cfg_pending;
  logic            swap_pending;
  logic            req_d;
  logic [31:0]     shadow_rows;
  logic [31:0]     shadow_cols;
  logic [31:0]     shadow_bitdepth;
  logic [31:0]     shadow_lsb_blank;
  logic [RC_W-1:0] rcnt;
  logic [WD_W-1:0] wd;

  logic cfg_ok;
  logic accept;
  logic req_edge;
  logic swap_want;
  logic do_swap;
  logic wd_expire;
  logic wd_fire;
  logic rst_last;

  always_comb begin
    cfg_ok = (cfg_n_rows >= 32'd2) && (cfg_n_rows <= N_ROWS_MAX) && !cfg_n_rows[0] &&
             (cfg_n_cols >= 32'd1) && (cfg_n_cols <= N_COLS_MAX) &&
             (cfg_bitdepth >= 32'd1) && (cfg_bitdepth <= BITDEPTH_MAX) &&
             (cfg_lsb_blank >= 32'd1) && (cfg_lsb_blank <= LSB_BLANK_MAX);
  end

  // The pending flag holds an edge until a frame boundary; holding the request
  // high after an ack produces no further edge, so no second swap.
  assign accept    = cfg_valid && cfg_ready;
  assign req_edge  = wr_swap_req && !req_d;
  assign swap_want = swap_pending || req_edge;
  assign wd_expire = (wd == WD_W'(FRAME_TIMEOUT - 1));
  assign wd_fire   = (state == RUN) && !frame_done && wd_expire;
  assign rst_last  = (rcnt == RC_W'(RST_CYCLES - 1));

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_swap  = 1'b0;
    case (state)
      IDLE: begin
        do_swap = swap_want;
        if (run_en || cfg_pending) state_nx = LOAD;
      end
      LOAD: state_nx = PRST;
      PRST: if (rst_last) state_nx = RUN;
      RUN: begin
        if (frame_done) begin
          do_swap = swap_want;
          if (cfg_pending) state_nx = LOAD;
        end else if (wd_expire) begin
          state_nx = LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!run_en && (state != IDLE)) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      panel_en         <= 1'b0;
      panel_rst        <= 1'b1;
      panel_n_rows     <= N_ROWS_MAX;
      panel_n_cols     <= N_COLS_MAX;
      panel_bitdepth   <= BITDEPTH_MAX;
      panel_lsb_blank  <= LSB_BLANK_MAX;
      shadow_rows      <= '0;
      shadow_cols      <= '0;
      shadow_bitdepth  <= '0;
      shadow_lsb_blank <= '0;
      disp_buffer      <= 1'b0;
      wr_buffer        <= 1'b1;
      cfg_ready        <= 1'b1;
      cfg_err          <= 1'b0;
      cfg_pending      <= 1'b0;
      wr_swap_ack      <= 1'b0;
      swap_pending     <= 1'b0;
      req_d            <= 1'b0;
      fault            <= 1'b0;
      rcnt             <= '0;
      wd               <= '0;
    end else begin
      req_d     <= wr_swap_req;
      // Outputs follow the next state so they line up with the state they describe.
      panel_en  <= (state_nx == RUN);
      panel_rst <= (state_nx == PRST);
      rcnt      <= ((state == PRST) && (state_nx == PRST)) ? rcnt + 1'b1 : '0;
      wd        <= ((state == RUN) && (state_nx == RUN) && !frame_done) ? wd + 1'b1 : '0;

      if (wd_fire) fault <= 1'b1;

      wr_swap_ack <= do_swap;
      disp_buffer <= disp_buffer ^ do_swap;
      wr_buffer   <= ~(disp_buffer ^ do_swap);
      if (do_swap)       swap_pending <= 1'b0;
      else if (req_edge) swap_pending <= 1'b1;

      if ((state == LOAD) && cfg_pending) begin
        panel_n_rows    <= shadow_rows;
        panel_n_cols    <= shadow_cols;
        panel_bitdepth  <= shadow_bitdepth;
        panel_lsb_blank <= shadow_lsb_blank;
        cfg_pending     <= 1'b0;
        cfg_ready       <= 1'b1;
      end

      // cfg_ready is low whenever a config is pending, so this never collides with the copy above.
      if (accept) begin
        if (cfg_ok) begin
          shadow_rows      <= cfg_n_rows;
          shadow_cols      <= cfg_n_cols;
          shadow_bitdepth  <= cfg_bitdepth;
          shadow_lsb_blank <= cfg_lsb_blank;
          cfg_pending      <= 1'b1;
          cfg_ready        <= 1'b0;
          cfg_err          <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/panel_frame_sched.md
# panel_frame_sched

Frame-level scheduler sitting between the host/config logic and `ledpanel`. It owns the double-buffer index for the panel framebuffer BRAM and hands buffers between the frame writer and the panel at frame boundaries. It shadows panel configuration so new settings take effect only between frames. It sequences `ledpanel`'s enable and reset, and restarts the panel if frames stop completing.

## Interface
- `N_ROWS_MAX`, 64, upper bound for `cfg_n_rows`
- `N_COLS_MAX`, 256, upper bound for `cfg_n_cols`
- `BITDEPTH_MAX`, 8, upper bound for `cfg_bitdepth`
- `LSB_BLANK_MAX`, 200, upper bound for `cfg_lsb_blank`
- `RST_CYCLES`, 4, panel reset pulse length in cycles (≥1)
- `FRAME_TIMEOUT`, 2**24, watchdog limit in cycles between `frame_done` pulses

Ports:
- `clk` in 1: single clock
- `ctrl_rst` in 1: reset, asynchronous, active-high
- `run_en` in 1: 1 = display running
- `cfg_n_rows`, `cfg_n_cols`, `cfg_bitdepth`, `cfg_lsb_blank` in 32 each: proposed config
- `cfg_valid` in 1 / `cfg_ready` out 1: config handshake
- `cfg_err` out 1: last offered config was rejected
- `wr_swap_req` in 1 / `wr_swap_ack` out 1: writer finished a frame, requests swap
- `wr_buffer` out 1: buffer the writer may fill, always `~disp_buffer`
- `frame_done` in 1: one-cycle pulse from the panel at the end of each frame
- `disp_buffer` out 1: buffer select to BRAM read port
- `panel_en`, `panel_rst` out 1: drive `ledpanel` `ctrl_en` / `ctrl_rst`
- `panel_n_rows`, `panel_n_cols`, `panel_bitdepth`, `panel_lsb_blank` out 32 each: active config
- `fault` out 1: sticky watchdog flag

## Operation
- **States:** IDLE, LOAD, PRST, RUN.
- **Reset values:**
  - State IDLE. `panel_en`=0, `panel_rst`=1.
  - Active config = the four `*_MAX` parameters.
  - `disp_buffer`=0, `wr_buffer`=1.
  - `cfg_ready`=1, `cfg_err`=0, `wr_swap_ack`=0, `fault`=0.
  - No config or swap pending. Watchdog = 0.
- **Config acceptance:**
  - A config is accepted when `cfg_valid && cfg_ready`.
  - It is valid if all hold: 2 ≤ rows ≤ N_ROWS_MAX and rows even; 1 ≤ cols ≤ N_COLS_MAX; 1 ≤ bitdepth ≤ BITDEPTH_MAX; 1 ≤ lsb_blank ≤ LSB_BLANK_MAX. Compare unsigned, full 32 bits.
  - Valid: copy into the shadow, set cfg-pending, drop `cfg_ready`, clear `cfg_err`.
  - Invalid: discard, set `cfg_err`, keep `cfg_ready`=1.
  - `cfg_ready` returns to 1 the cycle after the shadow is copied into the active config. There is one pending slot.
- **Swap request:**
  - On the rising edge of `wr_swap_req`, swap-pending is set.
  - When the swap executes, `disp_buffer` toggles and `wr_swap_ack` pulses for exactly one cycle.
  - After an ack, the request is ignored until `wr_swap_req` is sampled low.
- **IDLE:** `panel_en`=0, `panel_rst`=0.
  - A pending swap executes immediately.
  - A pending config goes to LOAD.
  - When `run_en`=1, go to LOAD.
- **LOAD (1 cycle):** if cfg-pending, active ← shadow and clear pending. `panel_en`=0. Next state PRST.
- **PRST:** `panel_rst`=1 and `panel_en`=0 for RST_CYCLES cycles, then RUN. The watchdog clears on exit.
- **RUN:** `panel_en`=1. On a `frame_done` pulse:
  - If swap pending, execute the swap.
  - If cfg pending, go to LOAD.
  - If both are pending, do both on the same pulse.
  - If a `wr_swap_req` rising edge and `frame_done` arrive in the same cycle, the swap executes on that pulse.
- **`run_en`:** `run_en`=0 in any state other than IDLE → IDLE next cycle. Pending swap and config are retained.
- **Watchdog:**
  - Counts cycles in RUN and clears on `frame_done`.
  - At FRAME_TIMEOUT−1 without `frame_done`: set `fault` and go to LOAD.
  - `fault` clears only on `ctrl_rst`.
- **`ctrl_rst` mid-operation:** all state returns to reset values asynchronously. A pending swap is lost; no ack is issued.

## Timing
- All outputs are registered. `ctrl_rst` takes effect without a clock edge; release is sampled on the next `clk`.
- Swap latency in RUN: `frame_done` in cycle N → `disp_buffer` toggles and `wr_swap_ack`=1 in cycle N+1.
- Swap latency in IDLE: request edge sampled in cycle N → ack in cycle N+1.
- Config latency in RUN: `frame_done` in cycle N → LOAD in N+1 → active config updated and PRST entered in N+2 → `panel_rst`=1 for cycles N+2…N+1+RST_CYCLES → `panel_en`=1 from N+2+RST_CYCLES.
- Cold start: `run_en` rises in cycle N → `panel_en`=1 in cycle N+2+RST_CYCLES.
- `cfg_err` updates the cycle after the handshake.

## Test plan
- **Reset defaults:** assert `ctrl_rst` → all outputs at reset values; `panel_n_cols`=256; `panel_rst`=1 while reset is held.
- **Cold start:** `run_en`=1 at cycle 10 → `panel_rst` high for cycles 12–15; `panel_en`=1 from cycle 16.
- **Swap in RUN:** `wr_swap_req` high, then `frame_done` at cycle 100 → `disp_buffer` 0→1 and `wr_swap_ack` pulses at cycle 101. Holding req high afterwards produces no second ack.
- **Config change:** offer rows=32, cols=128, bitdepth=6, lsb=50 → `cfg_ready`=0. At the next `frame_done` the panel goes through LOAD/PRST and `panel_n_rows`=32, and `cfg_ready`=1 again. Offering bitdepth=9 → `cfg_err`=1 and the active config is unchanged.
- **Simultaneous swap and config:** both pending at one `frame_done` → buffer toggles and panel restarts with the new config in the same frame gap.
- **Watchdog and mid-run reset:** no `frame_done` for FRAME_TIMEOUT cycles (bench override 64) → `fault`=1 and the panel re-resets. `ctrl_rst` pulse mid-PRST → immediate IDLE, `fault`=0.
